ahb_sram_ctrl: RTL

- Parametrised AHB-Lite SRAM slave with posted writes. Next generation of the on-chip data-SRAM slave.
- Generalised in data width, bank count and bank depth; adds correct SEQ/NONSEQ burst handling, configurable wait states, a two-cycle ERROR response, and a 1-entry write buffer with read forwarding.
- Sits on the AHB interconnect as a memory slave. Instantiates BANK_NUM single-port byte-enable SRAM banks.

---
 rtl/ahb_sram_ctrl_pkg.sv | 24 ++
 rtl/ahb_sram_ctrl_if.sv | 27 ++
 rtl/ahb_sram_ctrl_sram_sp_be.sv | 28 ++
 rtl/ahb_sram_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_ctrl_pkg.sv
// rtl/ahb_sram_ctrl_pkg.sv - AHB-Lite codes and controller state type shared by the SRAM slave bundle
package ahb_sram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // ERR1 is the stalled first cycle of the two-cycle error response, ERR2 the ready one
    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } resp_state_e;

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// rtl/ahb_sram_ctrl_if.sv - AHB-Lite slave-port signal bundle with master/slave views
interface ahb_sram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic              hwrite;
    logic              hready;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] hwdata;
    logic [ADDR_W-1:0] haddr;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, hwrite, hready, hsize, hburst, htrans, hwdata, haddr,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, hwrite, hready, hsize, hburst, htrans, hwdata, haddr,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_ctrl_sram_sp_be.sv
// rtl/ahb_sram_ctrl_sram_sp_be.sv - single-port byte-enable SRAM bank, active-low cs/we, 1-cycle read
module ahb_sram_ctrl_sram_sp_be #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          cs_n,
    input  logic          we_n,
    input  logic [AW-1:0] addr,
    input  logic [DW/8-1:0] be,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    // rdata only moves on a read, so it holds the last read word across writes
    always_ff @(posedge clk) begin
        if (!cs_n) begin
            if (we_n) begin
                rdata <= mem[addr];
            end else begin
                for (int i = 0; i < DW / 8; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end
endmodule

// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite SRAM slave with posted-write buffer, wait states and error response
module ahb_sram_ctrl
    import ahb_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BANK_NUM    = 2,
    parameter int BANK_AW     = 13,
    parameter int WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hresetn,
    ahb_sram_ctrl_if.slave bus
);
    localparam int STRB  = DATA_W / 8;
    localparam int OFF_W = $clog2(STRB);
    localparam int BNK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
    localparam int BS    = BANK_AW + OFF_W;
    localparam logic [2:0]      MAX_SIZE  = 3'(OFF_W);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(BANK_NUM) << BS;

    logic [OFF_W-1:0]   a_off;
    logic [BANK_AW-1:0] a_word;
    logic [BNK_W-1:0]   a_bank;
    logic [2*STRB-1:0]  size_mask;
    logic [STRB-1:0]    a_be;
    logic               a_err, accept, acc_ok, acc_err, rd_issue;

    resp_state_e        state, state_next;
    logic [2:0]         wait_cnt;
    logic               hreadyout;
    logic [1:0]         hresp;

    logic               dp_valid, dp_write, rd_first;
    logic [BNK_W-1:0]   dp_bank;
    logic [BANK_AW-1:0] dp_word;
    logic [STRB-1:0]    dp_be;
    logic               dp_done, wr_done;

    logic               wb_valid, wb_load, wb_commit, fwd_hit;
    logic [BNK_W-1:0]   wb_bank;
    logic [BANK_AW-1:0] wb_word;
    logic [STRB-1:0]    wb_be;
    logic [DATA_W-1:0]  wb_data;

    logic               p_en, p_we;
    logic [BNK_W-1:0]   p_bank;
    logic [BANK_AW-1:0] p_word;
    logic [STRB-1:0]    p_be;
    logic [DATA_W-1:0]  p_wdata;

    logic [DATA_W-1:0]  bank_rdata [BANK_NUM];
    logic [DATA_W-1:0]  rd_merged, hrdata_q;
    logic               unused_ok;

    assign a_off     = bus.haddr[OFF_W-1:0];
    assign a_word    = bus.haddr[OFF_W +: BANK_AW];
    assign a_bank    = bus.haddr[BS +: BNK_W];
    assign size_mask = ((2*STRB)'(1) << (32'd1 << bus.hsize)) - (2*STRB)'(1);
    assign a_be      = STRB'(size_mask << a_off);
    assign a_err     = (bus.hsize > MAX_SIZE)
                     || ((a_off & OFF_W'((32'd1 << bus.hsize) - 32'd1)) != '0)
                     || ({1'b0, bus.haddr} >= MEM_BYTES);

    assign accept    = bus.hsel && bus.hready
                     && (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    assign acc_ok    = accept && !a_err;
    assign acc_err   = accept && a_err;
    assign rd_issue  = acc_ok && !bus.hwrite;
    assign unused_ok = ^bus.hburst;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_OKAY;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        hreadyout  = (wait_cnt == 3'd0);
        hresp      = HRESP_OKAY;
        case (state)
            ST_OKAY: if (acc_err) state_next = ST_ERR1;
            ST_ERR1: begin
                state_next = ST_ERR2;
                hreadyout  = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ST_ERR2: begin
                state_next = acc_err ? ST_ERR1 : ST_OKAY;
                hresp      = HRESP_ERROR;
            end
            default: state_next = ST_OKAY;
        endcase
    end

    assign dp_done   = dp_valid && hreadyout;
    assign wr_done   = dp_done && dp_write;
    // A read address phase owns the port, so the buffer drains on the next non-read cycle
    assign wb_commit = wb_valid && !rd_issue;
    assign wb_load   = wr_done && (rd_issue || wb_valid);
    assign fwd_hit   = wb_valid && (wb_bank == dp_bank) && (wb_word == dp_word);

    always_comb begin
        p_en    = 1'b0;
        p_we    = 1'b0;
        p_bank  = a_bank;
        p_word  = a_word;
        p_be    = a_be;
        p_wdata = wb_data;
        if (rd_issue) begin
            p_en = 1'b1;
        end else if (wb_valid) begin
            p_en   = 1'b1;
            p_we   = 1'b1;
            p_bank = wb_bank;
            p_word = wb_word;
            p_be   = wb_be;
        end else if (wr_done) begin
            p_en    = 1'b1;
            p_we    = 1'b1;
            p_bank  = dp_bank;
            p_word  = dp_word;
            p_be    = dp_be;
            p_wdata = bus.hwdata;
        end
    end

    always_comb begin
        rd_merged = bank_rdata[dp_bank];
        for (int i = 0; i < STRB; i++) begin
            if (fwd_hit && wb_be[i]) rd_merged[i*8 +: 8] = wb_data[i*8 +: 8];
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_bank  <= '0;
            dp_word  <= '0;
            dp_be    <= '0;
            rd_first <= 1'b0;
            wait_cnt <= 3'd0;
            hrdata_q <= '0;
            wb_valid <= 1'b0;
            wb_bank  <= '0;
            wb_word  <= '0;
            wb_be    <= '0;
            wb_data  <= '0;
        end else begin
            if (bus.hready) begin
                dp_valid <= acc_ok;
                dp_write <= bus.hwrite;
                dp_bank  <= a_bank;
                dp_word  <= a_word;
                dp_be    <= a_be;
                rd_first <= rd_issue;
            end else begin
                rd_first <= 1'b0;
            end
            if (acc_ok)                wait_cnt <= 3'(WAIT_STATES);
            else if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
            if (rd_first) hrdata_q <= rd_merged;
            if (wb_load) begin
                wb_valid <= 1'b1;
                wb_bank  <= dp_bank;
                wb_word  <= dp_word;
                wb_be    <= dp_be;
                wb_data  <= bus.hwdata;
            end else if (wb_commit) begin
                wb_valid <= 1'b0;
            end
        end
    end

    assert property (@(posedge hclk) disable iff (!hresetn)
        !(wb_load && wb_valid && !wb_commit));

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        ahb_sram_ctrl_sram_sp_be #(
            .AW (BANK_AW),
            .DW (DATA_W)
        ) u_sram (
            .clk   (hclk),
            .cs_n  (!(p_en && (p_bank == BNK_W'(b)))),
            .we_n  (!p_we),
            .addr  (p_word),
            .be    (p_be),
            .wdata (p_wdata),
            .rdata (bank_rdata[b])
        );
    end

    assign bus.hreadyout = hreadyout;
    assign bus.hresp     = hresp;
    assign bus.hrdata    = rd_first ? rd_merged : hrdata_q;
endmodule
